// File: rtl/mod12_wrap_monitor.sv
`default_nettype none
// ------------------------------------------------------------------
// mod12_wrap_monitor: classifies mod-12 counter steps, accumulates
// wraps and queues one event per wrap.                      Rev 1.0
// ------------------------------------------------------------------
module mod12_wrap_monitor #(
   parameter int FIFO_DEPTH = 4,
   parameter int WCNT_W     = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [3:0]        count_in,
   input  logic              load_in,
   output logic [WCNT_W-1:0] wrap_count,
   output logic              evt_valid,
   output logic [WCNT_W:0]   evt_data,
   input  logic              evt_ready,
   output logic              illegal,
   output logic              jump_err,
   output logic              overflow
);

   localparam int         C_PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [3:0] C_MAX   = 4'd11;

   logic [3:0]        cur_q, cur_d, prev_q, prev_d;
   logic              ld_q, ld_d, ld_qq, ld_qd;
   logic              seen_q, seen_d, pair_valid_q, pair_valid_d;
   logic [WCNT_W-1:0] wrap_count_q, wrap_count_d;
   logic              illegal_q, illegal_d, jump_err_q, jump_err_d;
   logic              overflow_q, overflow_d;
   logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [C_PTR_W:0]  occ_q, occ_d;
   logic [WCNT_W:0]   mem_q [FIFO_DEPTH];
   logic [WCNT_W:0]   mem_d [FIFO_DEPTH];

   logic       w_classify, w_is_hold, w_is_inc, w_is_dec;
   logic       w_up_wrap, w_dn_wrap, w_wrap, w_jump;
   logic [3:0] w_prev_inc, w_prev_dec;
   logic       w_full, w_empty, w_push, w_pop;

   // A step is only meaningful once two real samples exist and the earlier
   // one was not accompanied by a load.
   always_comb begin
      w_classify = pair_valid_q && (prev_q <= C_MAX) && (cur_q <= C_MAX) && !ld_qq;
      w_prev_inc = (prev_q == C_MAX) ? 4'd0 : prev_q + 4'd1;
      w_prev_dec = (prev_q == 4'd0) ? C_MAX : prev_q - 4'd1;
      w_is_hold  = (cur_q == prev_q);
      w_is_inc   = (cur_q == w_prev_inc);
      w_is_dec   = (cur_q == w_prev_dec);
      w_up_wrap  = w_classify && w_is_inc && (prev_q == C_MAX);
      w_dn_wrap  = w_classify && w_is_dec && (prev_q == 4'd0);
      w_wrap     = w_up_wrap || w_dn_wrap;
      w_jump     = w_classify && !w_is_hold && !w_is_inc && !w_is_dec;
   end

   always_comb begin
      w_full  = (occ_q == (C_PTR_W + 1)'(FIFO_DEPTH));
      w_empty = (occ_q == '0);
      w_pop   = !w_empty && evt_ready;
      w_push  = w_wrap && (!w_full || w_pop);
   end

   always_comb begin
      cur_d        = count_in;
      prev_d       = cur_q;
      ld_d         = load_in;
      ld_qd        = ld_q;
      seen_d       = 1'b1;
      pair_valid_d = seen_q;
      illegal_d    = illegal_q || (cur_q > C_MAX);
      jump_err_d   = jump_err_q || w_jump;
      overflow_d   = overflow_q || (w_wrap && !w_push);
      wrap_count_d = wrap_count_q;
      if (w_up_wrap) begin
         wrap_count_d = wrap_count_q + WCNT_W'(1);
      end else if (w_dn_wrap) begin
         wrap_count_d = wrap_count_q - WCNT_W'(1);
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (w_push) begin
         mem_d[wr_ptr_q] = {w_up_wrap, wrap_count_d};
         wr_ptr_d        = wr_ptr_q + C_PTR_W'(1);
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
      end
      case ({w_push, w_pop})
         2'b10:   occ_d = occ_q + (C_PTR_W + 1)'(1);
         2'b01:   occ_d = occ_q - (C_PTR_W + 1)'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cur_q        <= '0;
         prev_q       <= '0;
         ld_q         <= 1'b0;
         ld_qq        <= 1'b0;
         seen_q       <= 1'b0;
         pair_valid_q <= 1'b0;
         wrap_count_q <= '0;
         illegal_q    <= 1'b0;
         jump_err_q   <= 1'b0;
         overflow_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         occ_q        <= '0;
      end else begin
         cur_q        <= cur_d;
         prev_q       <= prev_d;
         ld_q         <= ld_d;
         ld_qq        <= ld_qd;
         seen_q       <= seen_d;
         pair_valid_q <= pair_valid_d;
         wrap_count_q <= wrap_count_d;
         illegal_q    <= illegal_d;
         jump_err_q   <= jump_err_d;
         overflow_q   <= overflow_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the queue is empty.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign wrap_count = wrap_count_q;
   assign evt_valid  = !w_empty;
   assign evt_data   = w_empty ? '0 : mem_q[rd_ptr_q];
   assign illegal    = illegal_q;
   assign jump_err   = jump_err_q;
   assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: doc/mod12_wrap_monitor.md
# mod12_wrap_monitor

Downstream observer for the mod-12 up/down counter. It samples the counter's 4-bit output and load strobe every cycle and classifies each step as hold, increment, decrement, load, or error. It counts wrap-arounds (11→0 up, 0→11 down) in a wider signed-modulo accumulator and queues one event per wrap in a small FIFO with a valid/ready output. It also raises sticky flags for illegal values, unexplained jumps, and dropped events.

## Interface
Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of 2, ≥2.
- WCNT_W, 8: width of the wrap accumulator.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- count_in  in  4  counter output (data_out of the mod-12 counter).
- load_in  in  1  counter load strobe, the same signal the counter sees.
- wrap_count  out  WCNT_W  wrap accumulator: +1 per up-wrap, −1 per down-wrap, modulo 2^WCNT_W.
- evt_valid  out  1  FIFO head valid.
- evt_data  out  WCNT_W+1  {dir, wrap_count after this wrap}; dir 1=up, 0=down.
- evt_ready  in  1  consumer accepts the head when evt_valid && evt_ready.
- illegal  out  1  sticky: a sampled count_in was >11.
- jump_err  out  1  sticky: a non-load step was not hold/±1 mod 12.
- overflow  out  1  sticky: a wrap event was dropped because the FIFO was full.

## Operation
- Sampling: each edge registers cur_q<=count_in, prev_q<=cur_q, ld_q<=load_in, ld_qq<=ld_q.
- A step (prev_q→cur_q) was caused by ld_qq, the load sampled together with prev_q.
- A pair counts only when the pair-valid flag is set, which happens on the 2nd edge after reset release.
- Step classification, combinational on (prev_q, cur_q, ld_qq) when the pair is valid:
  - either value >11: no classification. Illegal detection uses cur_q alone.
  - ld_qq=1: load. No wrap, no error, whatever the values.
  - cur=prev: hold.
  - cur=(prev+1) mod 12: inc. prev=11 gives an up-wrap.
  - cur=(prev+11) mod 12: dec. prev=0 gives a down-wrap.
  - anything else: jump_err set.
- Wrap handling, registered on the next edge:
  - wrap_count ±1, wrapping modulo 2^WCNT_W (255+1=0, 0−1=255).
  - Push {dir, new wrap_count} into the FIFO.
- FIFO behaviour:
  - Pop when evt_valid && evt_ready.
  - Push while full without a same-cycle pop: the event is dropped and overflow is set. wrap_count still updates.
  - Full with simultaneous push and pop: both happen, occupancy unchanged.
  - Empty with a push: no bypass. evt_valid rises after the push edge.
- Sticky flags clear only on reset.

## Timing
- Reset (reset=0 at an edge):
  - Outputs: wrap_count=0, evt_valid=0, evt_data=0, illegal=0, jump_err=0, overflow=0.
  - Internal state: FIFO emptied, pair-valid cleared.
- Reset mid-operation discards all queued events.
- Latency: count_in sampled at edge k completes a wrap pair with the value sampled at edge k−1. wrap_count and FIFO update at edge k+1, and evt_valid is visible after edge k+1 if the FIFO was empty.
- illegal: set at edge k+1 for a value >11 sampled at edge k.
- jump_err: set at edge k+1 for the offending pair completed at edge k.
- evt_data is stable while evt_valid=1 && evt_ready=0.
- Throughput: one wrap per cycle sustainable. The 11→0→11 pattern on consecutive cycles gives up then down events back to back.

## Test plan
- Reset: reset=0 for 3 edges with count_in=5, load_in=0, then release → all outputs 0. Samples on the first edge after release produce no event or error.
- Up-wrap: count_in 9,10,11,0,1 with load_in=0, evt_ready=1 → one event, evt_data={1,8'd1}, wrap_count=1, no flags.
- Down-wrap from reset: count_in 1,0,11,10 → evt_data={0,8'd255}, wrap_count=255.
- Load masking: count_in 11 with load_in=1 on the same edge, then 0; later 7 with load_in=1, then 3 → no event, jump_err=0, wrap_count unchanged.
- Backpressure: evt_ready=0 with 5 up-wraps → evt_data held at {1,1}, overflow=1, wrap_count=5. Then evt_ready=1 → drains 1,2,3,4 on consecutive cycles and evt_valid drops.
- Errors: count_in=13 → illegal=1 one edge after the sample. 7→3 with load_in=0 → jump_err=1. Both stay set until reset.
